// File: rtl/instr_stream_loader_if.sv
// ============================================================================
//  Module      : instr_stream_loader_if
//  Description : Byte-source and instruction-stream bundle for the boot loader.
//                master = byte source / observer (drives rx_data, rx_valid)
//                slave  = instr_stream_loader (drives replay and status outputs)
//  Signals     : rx_data[7:0], rx_valid     received byte + single-cycle strobe
//                instr_o[7:0]               byte stream to instruction memory
//                cpu_rst_o                  1 = hold CPU core in reset
//                load_done, load_err        image accepted / frame rejected
//                rx_ovr_o                   sticky: byte dropped during replay
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_stream_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] instr_o;
    logic       cpu_rst_o;
    logic       load_done;
    logic       load_err;
    logic       rx_ovr_o;

    modport master (
        output rx_data, rx_valid,
        input  instr_o, cpu_rst_o, load_done, load_err, rx_ovr_o
    );

    modport slave (
        input  rx_data, rx_valid,
        output instr_o, cpu_rst_o, load_done, load_err, rx_ovr_o
    );
endinterface

`default_nettype wire

// File: rtl/instr_stream_loader.sv
// ============================================================================
//  Module      : instr_stream_loader
//  Description : Boot loader upstream of the instruction memory. Collects a
//                length-prefixed image (LEN_HI, LEN_LO, N payload bytes) from
//                a byte source into a buffer, then replays it on instr_o as
//                0xFE, payload, 0x00 padding to a word boundary, 0xFF, keeping
//                the CPU in reset until the memory write pipeline has drained.
//  Ports       : clk, reset (async, active-high)
//                bus  : instr_stream_loader_if.slave (rx in, replay/status out)
//  Parameters  : DEPTH   payload buffer size in bytes
//                TIMEOUT max idle cycles between bytes inside a frame
//                DRAIN   cycles cpu_rst_o stays high after the 0xFF marker
//  Option      : INSTR_LOADER_CHECKSUM_EN - frame carries a trailing checksum
//                byte (sum of payload mod 256) checked in the CHK state.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_stream_loader #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1000000,
    parameter int DRAIN   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_stream_loader_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = ($clog2(DRAIN + 1) > 2) ? $clog2(DRAIN + 1) : 2;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_LO = 4'd1;
    localparam logic [3:0] S_RECV   = 4'd2;
    localparam logic [3:0] S_CHK    = 4'd3;
    localparam logic [3:0] S_START  = 4'd4;
    localparam logic [3:0] S_STREAM = 4'd5;
    localparam logic [3:0] S_PAD    = 4'd6;
    localparam logic [3:0] S_STOP   = 4'd7;
    localparam logic [3:0] S_DRAIN  = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd10;

    localparam logic [7:0] c_MARK_START = 8'hFE;
    localparam logic [7:0] c_MARK_STOP  = 8'hFF;

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;

    logic [7:0]       r_mem [DEPTH];
    logic [7:0]       r_len_hi;
    logic [15:0]      r_len;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_bad;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_cnt;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    logic [7:0]       r_instr;
    logic             r_cpu_rst;
    logic             r_load_done;
    logic             r_load_err;
    logic             r_rx_ovr;

    logic [7:0]       w_instr_d;
    logic             w_cpu_rst_d;
    logic             w_load_done_d;
    logic             w_load_err_d;

    logic [15:0]      w_rx_len;
    logic             w_last_byte;
    logic             w_stream_end;
    logic             w_need_pad;
    logic             w_timeout;
    logic             w_waiting;
    logic             w_replaying;

    assign w_rx_len     = {r_len_hi, bus.rx_data};
    assign w_last_byte  = (16'(r_wr_ptr) + 16'd1) == r_len;
    // rd_ptr counts bytes already placed on instr_o, so equality means the
    // final payload byte is on the bus this cycle.
    assign w_stream_end = 16'(r_rd_ptr) == r_len;
    // Padding length (4 - N%4) % 4 is non-zero exactly when N%4 != 0.
    assign w_need_pad   = r_len[1:0] != 2'd0;
    assign w_timeout    = r_gap == GAP_W'(TIMEOUT);
    assign w_waiting    = (r_state == S_LEN_LO) || (r_state == S_RECV) ||
                          (r_state == S_CHK);
    assign w_replaying  = (r_state == S_START) || (r_state == S_STREAM) ||
                          (r_state == S_PAD)   || (r_state == S_STOP)   ||
                          (r_state == S_DRAIN);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.rx_valid) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    if ((w_rx_len == 16'd0) || (w_rx_len > 16'(DEPTH)))
                        w_state_nxt = S_ERR;
                    else
                        w_state_nxt = S_RECV;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_RECV: begin
                if (bus.rx_valid) begin
                    if (w_last_byte) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        w_state_nxt = S_CHK;
`else
                        // The final byte's own 0xFF check is folded in here
                        // because r_bad only updates on this same edge.
                        if (r_bad || (bus.rx_data == 8'hFF))
                            w_state_nxt = S_ERR;
                        else
                            w_state_nxt = S_START;
`endif
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (bus.rx_valid) begin
                    if (r_bad || (bus.rx_data != r_csum))
                        w_state_nxt = S_ERR;
                    else
                        w_state_nxt = S_START;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
`else
                w_state_nxt = S_ERR;
`endif
            end
            S_START: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_stream_end) w_state_nxt = w_need_pad ? S_PAD : S_STOP;
            end
            S_PAD: begin
                if (r_cnt == '0) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_state_nxt = (DRAIN == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values are a function of the state being entered, so
    // the registered outputs line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        w_instr_d     = 8'h00;
        w_cpu_rst_d   = 1'b1;
        w_load_done_d = 1'b0;
        w_load_err_d  = 1'b0;
        case (w_state_nxt)
            S_START:  w_instr_d = c_MARK_START;
            S_STREAM: w_instr_d = r_mem[r_rd_ptr[IDX_W-1:0]];
            S_STOP:   w_instr_d = c_MARK_STOP;
            S_DONE: begin
                w_cpu_rst_d   = 1'b0;
                w_load_done_d = 1'b1;
            end
            S_ERR:    w_load_err_d = 1'b1;
            default:  w_instr_d = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Payload buffer (no reset: contents are only meaningful once written)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == S_RECV) && bus.rx_valid) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= bus.rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_hi    <= 8'h00;
            r_len       <= 16'h0000;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_bad       <= 1'b0;
            r_gap       <= '0;
            r_cnt       <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
            r_instr     <= 8'h00;
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_rx_ovr    <= 1'b0;
        end else begin
            r_instr     <= w_instr_d;
            r_cpu_rst   <= w_cpu_rst_d;
            r_load_done <= w_load_done_d;
            r_load_err  <= w_load_err_d;

            // Inter-byte gap counter, saturating at TIMEOUT.
            if (bus.rx_valid || !w_waiting)
                r_gap <= '0;
            else if (!w_timeout)
                r_gap <= r_gap + GAP_W'(1);

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.rx_valid) begin
                        r_len_hi <= bus.rx_data;
                        r_rx_ovr <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (bus.rx_valid) begin
                        r_len    <= w_rx_len;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_bad    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_csum   <= 8'h00;
`endif
                    end
                end
                S_RECV: begin
                    if (bus.rx_valid) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                        if (bus.rx_data == 8'hFF) r_bad <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_csum   <= r_csum + bus.rx_data;
`endif
                    end
                end
                default: begin
                    // Bytes arriving during replay are dropped but flagged.
                    if (w_replaying && bus.rx_valid) r_rx_ovr <= 1'b1;
                end
            endcase

            if (w_state_nxt == S_STREAM) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            // Shared down-counter for PAD and DRAIN, loaded with length-1.
            if ((w_state_nxt == S_PAD) && (r_state != S_PAD))
                r_cnt <= CNT_W'(2'd3 - r_len[1:0]);
            else if ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN))
                r_cnt <= CNT_W'(DRAIN - 1);
            else if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign bus.instr_o   = r_instr;
    assign bus.cpu_rst_o = r_cpu_rst;
    assign bus.load_done = r_load_done;
    assign bus.load_err  = r_load_err;
    assign bus.rx_ovr_o  = r_rx_ovr;

endmodule

`default_nettype wire
